// File: rtl/recirculacion_fifo.sv
// rtl/recirculacion_fifo.sv - registered forward/recirculate router with buffered probador FIFO (optional stats: RECIRC_STATS_EN)
module recirculacion_fifo #(
  parameter int LANES = 4,
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [LANES*WIDTH-1:0]       data_in,
  input  logic                         valid_in,
  input  logic [1:0]                   mode,
  output logic [LANES*WIDTH-1:0]       data_mux,
  output logic                         valid_mux,
  output logic [LANES*WIDTH-1:0]       data_probador,
  output logic                         valid_probador,
  input  logic                         ready_probador,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
  output logic                         fifo_full,
  output logic                         overflow
`ifdef RECIRC_STATS_EN
  ,
  output logic [15:0]                  fwd_cnt,
  output logic [15:0]                  drop_cnt
`endif
);

  localparam int DW = LANES * WIDTH;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [DW-1:0] r_data_mux;
  logic          r_valid_mux;
  logic          r_overflow;

  logic w_fwd;
  logic w_push;
  logic w_pop;
  logic w_full;
  logic w_nonempty;
  logic w_push_acc;
  logic w_drop;

  // Routing decision from mode and valid_in for the current cycle
  always_comb begin
    w_fwd  = 1'b0;
    w_push = 1'b0;
    case (mode)
      2'd0: begin
        w_fwd  = valid_in;
        w_push = ~valid_in;
      end
      2'd1: begin
        w_fwd  = valid_in;
      end
      2'd2: begin
        w_push = 1'b1;
      end
      default: begin
        w_fwd  = valid_in;
        w_push = valid_in;
      end
    endcase
  end

  assign w_nonempty = (r_count != '0);
  assign w_full     = (r_count == DEPTH_C);
  assign w_pop      = w_nonempty & ready_probador;
  // A full FIFO still accepts a push when the head leaves in the same cycle
  assign w_push_acc = w_push & (~w_full | w_pop);
  assign w_drop     = w_push & w_full & ~w_pop;

  // Forward path register: zero data on non-forwarded cycles, never stale
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_data_mux  <= '0;
      r_valid_mux <= 1'b0;
    end else begin
      r_data_mux  <= w_fwd ? data_in : '0;
      r_valid_mux <= w_fwd;
    end
  end

  // FIFO storage; contents need no reset because pointers and count gate visibility
  always_ff @(posedge clk) begin
    if (w_push_acc) begin
      r_mem[r_wr_ptr] <= data_in;
    end
  end

  // FIFO pointers, occupancy and sticky overflow flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push_acc) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_push_acc && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (!w_push_acc && w_pop) begin
        r_count <= r_count - 1'b1;
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

`ifdef RECIRC_STATS_EN
  logic [15:0] r_fwd_cnt;
  logic [15:0] r_drop_cnt;

  // Saturating event counters for forwarded words and dropped pushes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fwd_cnt  <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (w_fwd && r_fwd_cnt != 16'hFFFF) begin
        r_fwd_cnt <= r_fwd_cnt + 16'd1;
      end
      if (w_drop && r_drop_cnt != 16'hFFFF) begin
        r_drop_cnt <= r_drop_cnt + 16'd1;
      end
    end
  end

  assign fwd_cnt  = r_fwd_cnt;
  assign drop_cnt = r_drop_cnt;
`endif

  assign data_mux       = r_data_mux;
  assign valid_mux      = r_valid_mux;
  assign valid_probador = w_nonempty;
  assign data_probador  = w_nonempty ? r_mem[r_rd_ptr] : '0;
  assign fifo_count     = r_count;
  assign fifo_full      = w_full;
  assign overflow       = r_overflow;

endmodule

// File: tb/tb_recirculacion_fifo.sv
// tb/tb_recirculacion_fifo.sv - self-checking bench for recirculacion_fifo against a queue reference model
module tb_recirculacion_fifo;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] data_in;
  logic        valid_in;
  logic [1:0]  mode;
  logic [31:0] data_mux;
  logic        valid_mux;
  logic [31:0] data_probador;
  logic        valid_probador;
  logic        ready_probador;
  logic [3:0]  fifo_count;
  logic        fifo_full;
  logic        overflow;
`ifdef RECIRC_STATS_EN
  logic [15:0] fwd_cnt;
  logic [15:0] drop_cnt;
`endif

  recirculacion_fifo #(.LANES(4), .WIDTH(8), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .reset          (reset),
    .data_in        (data_in),
    .valid_in       (valid_in),
    .mode           (mode),
    .data_mux       (data_mux),
    .valid_mux      (valid_mux),
    .data_probador  (data_probador),
    .valid_probador (valid_probador),
    .ready_probador (ready_probador),
    .fifo_count     (fifo_count),
    .fifo_full      (fifo_full),
    .overflow       (overflow)
`ifdef RECIRC_STATS_EN
    ,
    .fwd_cnt        (fwd_cnt),
    .drop_cnt       (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  logic [31:0] mq[$];
  logic [31:0] exp_mux;
  logic        exp_vmux;
  logic        exp_ovf;
  int unsigned exp_fwd;
  int unsigned exp_drop;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string ctx);
    logic [31:0] head;
    head = (mq.size() != 0) ? mq[0] : 32'h0;
    check({ctx, ".data_mux"},       64'(data_mux),       64'(exp_mux));
    check({ctx, ".valid_mux"},      64'(valid_mux),      64'(exp_vmux));
    check({ctx, ".valid_probador"}, 64'(valid_probador), 64'(mq.size() != 0));
    check({ctx, ".data_probador"},  64'(data_probador),  64'(head));
    check({ctx, ".fifo_count"},     64'(fifo_count),     64'(mq.size()));
    check({ctx, ".fifo_full"},      64'(fifo_full),      64'(mq.size() == DEPTH));
    check({ctx, ".overflow"},       64'(overflow),       64'(exp_ovf));
`ifdef RECIRC_STATS_EN
    check({ctx, ".fwd_cnt"},        64'(fwd_cnt),        64'(exp_fwd));
    check({ctx, ".drop_cnt"},       64'(drop_cnt),       64'(exp_drop));
`endif
  endtask

  task automatic model_clear();
    mq.delete();
    exp_mux  = 32'h0;
    exp_vmux = 1'b0;
    exp_ovf  = 1'b0;
    exp_fwd  = 0;
    exp_drop = 0;
  endtask

  // One clock cycle: drive inputs, advance the model, check after the edge
  task automatic step(input string ctx, input logic [1:0] m, input logic v,
                      input logic [31:0] d, input logic rdy);
    bit fwd, push, pop, full;
    mode = m; valid_in = v; data_in = d; ready_probador = rdy;
    fwd  = v && (m != 2'd2);
    push = (m == 2'd2) || (m == 2'd0 && !v) || (m == 2'd3 && v);
    pop  = (mq.size() != 0) && rdy;
    full = (mq.size() == DEPTH);
    exp_mux  = fwd ? d : 32'h0;
    exp_vmux = fwd;
    if (fwd && exp_fwd < 65535) exp_fwd++;
    if (pop) void'(mq.pop_front());
    if (push) begin
      if (!full || pop) mq.push_back(d);
      else begin
        exp_ovf = 1'b1;
        if (exp_drop < 65535) exp_drop++;
      end
    end
    @(posedge clk);
    #1;
    check_all(ctx);
  endtask

  task automatic drain(input string ctx);
    for (int i = 0; i < 2 * DEPTH && mq.size() != 0; i++)
      step(ctx, 2'd1, 1'b0, $urandom, 1'b1);
  endtask

  initial begin
    reset = 1'b1; mode = 2'd1; valid_in = 1'b0; data_in = '0; ready_probador = 1'b0;
    model_clear();
    #1;
    check_all("reset_init");
    @(posedge clk); #1;
    @(negedge clk) reset = 1'b0;

    // Three words buffered, then async reset clears everything immediately
    step("pre_rst0", 2'd0, 1'b0, 32'h0000_0001, 1'b0);
    step("pre_rst1", 2'd0, 1'b0, 32'h0000_0002, 1'b0);
    step("pre_rst2", 2'd3, 1'b1, 32'h0000_0003, 1'b0);
    #2 reset = 1'b1;
    #1;
    model_clear();
    check_all("async_rst");
    @(negedge clk) reset = 1'b0;

    step("post_rst_push", 2'd2, 1'b0, 32'hA1B2C3D4, 1'b0);
    drain("post_rst_drain");

    // Legacy demux behaviour
    step("m0_fwd",  2'd0, 1'b1, 32'h11223344, 1'b0);
    step("m0_recv", 2'd0, 1'b0, 32'h55667788, 1'b0);
    drain("m0_drain");

    // Fill past depth with probador stalled: ninth word dropped, overflow sticks
    for (int i = 1; i <= DEPTH + 1; i++)
      step($sformatf("fill%0d", i), 2'd2, 1'b0, 32'hC0DE_0000 + i, 1'b0);
    step("hold_full", 2'd1, 1'b0, 32'h0, 1'b0);
    drain("fill_drain");

    // Full FIFO with simultaneous push and pop, across pointer wrap
    for (int i = 1; i <= DEPTH; i++)
      step($sformatf("refill%0d", i), 2'd2, 1'b1, 32'hBEEF_0000 + i, 1'b0);
    for (int i = 0; i < 20; i++)
      step($sformatf("pushpop%0d", i), 2'd2, 1'b0, 32'h5A5A_0000 + i, 1'b1);
    drain("pushpop_drain");

    // Mirror mode sends the same word to both paths
    step("m3_mirror", 2'd3, 1'b1, 32'hDEADBEEF, 1'b0);
    step("m3_idle",   2'd3, 1'b0, 32'h12345678, 1'b0);
    drain("m3_drain");

    // Randomised traffic against the reference model
    for (int i = 0; i < 400; i++)
      step($sformatf("rnd%0d", i), 2'($urandom_range(0, 3)), 1'($urandom),
           $urandom, 1'($urandom_range(0, 3) != 0));

    // Reset after random traffic
    #2 reset = 1'b1;
    #1;
    model_clear();
    check_all("final_rst");
    @(negedge clk) reset = 1'b0;
    step("final_fwd", 2'd1, 1'b1, 32'hCAFEF00D, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/recirculacion_fifo.md
Name: recirculacion_fifo

Overview:
- Parametrised, registered successor of the PHY TX four-lane recirculation demux.
- Per cycle, steers a LANES x WIDTH word either forward to the lane mux path or into a recirculation FIFO drained by the probador under a valid/ready handshake.
- Adds a routing mode, buffering, overflow detection and occupancy reporting.
- Sits between the byte-striping stage and the lane muxes.

Parameters:
- LANES, 4, number of byte lanes carried in parallel.
- WIDTH, 8, bits per lane.
- DEPTH, 8, recirculation FIFO depth in words; power of two, >= 2.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- data_in  input  LANES*WIDTH  lane k occupies bits [k*WIDTH +: WIDTH].
- valid_in  input  1  input word valid this cycle.
- mode  input  2  0 = by valid, 1 = force forward, 2 = force recirculate, 3 = mirror.
- data_mux  output  LANES*WIDTH  registered forward data.
- valid_mux  output  1  registered forward valid.
- data_probador  output  LANES*WIDTH  FIFO head word.
- valid_probador  output  1  FIFO non-empty.
- ready_probador  input  1  probador accepts head this cycle.
- fifo_count  output  $clog2(DEPTH+1)  current occupancy.
- fifo_full  output  1  fifo_count == DEPTH.
- overflow  output  1  sticky drop flag.

Behaviour:
- Reset (async assert, sync release): data_mux = 0, valid_mux = 0, FIFO empty, fifo_count = 0, valid_probador = 0, data_probador = 0, fifo_full = 0, overflow = 0.
- Routing, evaluated combinationally from mode and valid_in each cycle:
  - fwd = (mode==0 & valid_in) | (mode==1 & valid_in) | (mode==3 & valid_in).
  - push = (mode==0 & !valid_in) | (mode==2) | (mode==3 & valid_in).
  - Mode 0 matches the legacy demux. Mode 2 recirculates every cycle regardless of valid. Mode 3 sends the same word to both paths.
- Forward path, 1-cycle latency: on each edge, data_mux <= fwd ? data_in : 0 and valid_mux <= fwd. Non-forwarded cycles drive zero data, never stale data.
- FIFO:
  - Circular buffer with wr/rd pointers of $clog2(DEPTH) bits, wrapping modulo DEPTH.
  - pop = valid_probador & ready_probador.
  - data_probador = mem[rd_ptr] when non-empty, else 0.
  - No fall-through: a word pushed at edge k first appears at the output after edge k, so valid_probador rises the cycle after the first push.
- Boundary conditions:
  - Push while not full: store the word, increment wr_ptr.
  - Push while full with pop the same cycle: both occur, count unchanged, no overflow.
  - Push while full without pop: word dropped, pointers and count unchanged, overflow <= 1, held until reset.
  - Pop while empty: impossible, since valid_probador = 0.
  - Simultaneous push and pop when not full: count unchanged, both pointers advance.
  - fifo_count += push_accepted - pop. fifo_full derived combinationally from fifo_count.
  - ready_probador is ignored while empty.
- Reset mid-operation discards FIFO contents immediately (async); memory contents need not be cleared, only pointers and count.
- A mode change takes effect the same cycle; words already buffered are unaffected.

Optional Feature:
- Macro RECIRC_STATS_EN. When defined, adds two outputs:
  - fwd_cnt (16 bits): increments on every fwd cycle.
  - drop_cnt (16 bits): increments on every dropped push.
- Both counters reset to 0 and saturate at 16'hFFFF with no wrap.
- When undefined, neither port nor counter logic exists, and behaviour is otherwise identical.

Test Plan:
- Reset: assert reset mid-stream with 3 words buffered -> all outputs 0 immediately. After release, push 32'hA1B2C3D4 -> valid_probador = 1 one cycle later, fifo_count = 1.
- Mode 0, valid_in = 1, data_in = 32'h11223344 -> next cycle data_mux = 32'h11223344, valid_mux = 1, fifo_count unchanged. valid_in = 0, data_in = 32'h55667788 -> data_mux = 0, FIFO head = 32'h55667788.
- Mode 2, ready_probador = 0, push 9 words (DEPTH = 8) -> fifo_full = 1 after 8, ninth dropped, overflow = 1 and sticky. Drain -> words 1..8 in order, valid_probador = 0 after the 8th pop.
- FIFO full, push and ready_probador = 1 in the same cycle -> no overflow, count stays 8. Head advances to word 2 and the new word lands at tail; verify pointer wrap over 20 cycles of continuous push/pop.
- Mode 3, valid_in = 1, data_in = 32'hDEADBEEF -> next cycle data_mux = 32'hDEADBEEF and FIFO head = 32'hDEADBEEF.
- With RECIRC_STATS_EN: 5 forwards and 2 drops -> fwd_cnt = 5, drop_cnt = 2. Preload fwd_cnt at 16'hFFFE, 3 forwards -> fwd_cnt = 16'hFFFF.
